// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, ALU op codes
// and data-processing cmd field values.
package mc_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_MEMADR = 4'd2;
  localparam state_t S_MEMRD  = 4'd3;
  localparam state_t S_MEMWB  = 4'd4;
  localparam state_t S_MEMWR  = 4'd5;
  localparam state_t S_EXECR  = 4'd6;
  localparam state_t S_EXECI  = 4'd7;
  localparam state_t S_ALUWB  = 4'd8;
  localparam state_t S_BRANCH = 4'd9;

  // SHIFT carries the instruction's sh field in its low two bits.
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_ORR   = 4'd3;
  localparam logic [3:0] ALU_EOR   = 4'd4;
  localparam logic [3:0] ALU_MVN   = 4'd5;
  localparam logic [1:0] ALU_SHIFT = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_MVN = 4'b1111;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/mc_control_fsm_alu_dec.sv
// Combinational ALU decoder: maps the DP cmd/S/sh fields to an ALU op, flag
// write enables, result suppression and an unimplemented-encoding flag.
module alu_op_decode
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_W = 4
) (
  input  logic [5:0]       i_funct,
  input  logic [1:0]       i_sh,
  output logic [ALU_W-1:0] o_alu_ctrl,
  output logic [1:0]       o_flag_w,
  output logic             o_no_write,
  output logic             o_illegal
);

  logic [3:0] w_cmd;
  logic       w_s;
  logic [3:0] w_op;
  logic       w_known;
  logic       w_cmp;
  logic       w_absent;

  assign w_cmd = i_funct[4:1];
  assign w_s   = i_funct[0];

  always_comb begin
    w_op    = ALU_ADD;
    w_known = 1'b1;
    w_cmp   = 1'b0;
    case (w_cmd)
      CMD_ADD: w_op = ALU_ADD;
      CMD_SUB: w_op = ALU_SUB;
      CMD_AND: w_op = ALU_AND;
      CMD_ORR: w_op = ALU_ORR;
      CMD_EOR: w_op = ALU_EOR;
      CMD_MVN: w_op = ALU_MVN;
      CMD_MOV: w_op = {ALU_SHIFT, i_sh};
      CMD_TST: begin w_op = ALU_AND; w_cmp = 1'b1; end
      CMD_TEQ: begin w_op = ALU_EOR; w_cmp = 1'b1; end
      CMD_CMP: begin w_op = ALU_SUB; w_cmp = 1'b1; end
      CMD_CMN: begin w_op = ALU_ADD; w_cmp = 1'b1; end
      default: w_known = 1'b0;
    endcase
  end

  // Narrow builds cannot express ops whose code needs more than ALU_W bits.
  assign w_absent = (ALU_W < 4) && ((32'(w_op) >> ALU_W) != 32'd0);

  assign o_illegal  = ~w_known | w_absent | (w_cmp & ~w_s);
  assign o_alu_ctrl = w_op[ALU_W-1:0];
  assign o_flag_w   = {w_s, w_s & ((w_op == ALU_ADD) || (w_op == ALU_SUB))};
  assign o_no_write = w_cmp;

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle ARMv4 control FSM: FETCH/DECODE then memory, DP or branch paths,
// with memory wait states and a one-cycle Illegal pulse from DECODE.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_W      = 4,
  parameter bit USE_MEMRDY = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic [1:0]       sh,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             NextPC,
  output logic             AdrSrc,
  output logic             MemW,
  output logic             RegW,
  output logic             PCS,
  output logic [1:0]       ResultSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic [ALU_W-1:0] ALUControl,
  output logic [1:0]       FlagW,
  output logic             NoWrite,
  output logic             Illegal,
  output logic [3:0]       o_dbg_state
);

  state_t           r_state;
  state_t           w_next;
  logic             w_rdy;
  logic             w_bad;
  logic             w_rd_pc;
  logic [ALU_W-1:0] w_dec_alu;
  logic [1:0]       w_dec_flag;
  logic             w_dec_nw;
  logic             w_dec_ill;

  assign w_rdy       = USE_MEMRDY ? MemReady : 1'b1;
  assign w_rd_pc     = (Rd == 4'd15);
  assign w_bad       = (Op == 2'b11) || ((Op == OP_DP) && w_dec_ill);
  assign o_dbg_state = r_state;

  alu_op_decode #(.ALU_W(ALU_W)) u_alu_dec (
    .i_funct    (Funct),
    .i_sh       (sh),
    .o_alu_ctrl (w_dec_alu),
    .o_flag_w   (w_dec_flag),
    .o_no_write (w_dec_nw),
    .o_illegal  (w_dec_ill)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_rdy) w_next = S_DECODE;
      S_DECODE: begin
        if (w_bad)              w_next = S_FETCH;
        else if (Op == OP_MEM)  w_next = S_MEMADR;
        else if (Op == OP_BR)   w_next = S_BRANCH;
        else if (Funct[5])      w_next = S_EXECI;
        else                    w_next = S_EXECR;
      end
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_rdy) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (w_rdy) w_next = S_FETCH;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    MemW       = 1'b0;
    RegW       = 1'b0;
    PCS        = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = ALU_ADD[ALU_W-1:0];
    FlagW      = 2'b00;
    NoWrite    = 1'b0;
    Illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        IRWrite = w_rdy; NextPC = w_rdy;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        Illegal = w_bad;
      end
      S_MEMADR: begin ALUSrcB = 2'b01; ImmSrc = 2'b01; end
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB:  begin ResultSrc = 2'b01; RegW = 1'b1; PCS = w_rd_pc; end
      S_MEMWR:  begin AdrSrc = 1'b1; RegSrc = 2'b10; MemW = 1'b1; end
      S_EXECR:  ALUSrcB = 2'b00;
      S_EXECI:  begin ALUSrcB = 2'b01; ImmSrc = 2'b00; end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        RegW      = ~w_dec_nw;
        PCS       = w_rd_pc & ~w_dec_nw;
      end
      S_BRANCH: begin
        ALUSrcB = 2'b01; ImmSrc = 2'b10; RegSrc = 2'b01;
        ResultSrc = 2'b10; PCS = 1'b1;
      end
      default: ;
    endcase
    if ((r_state == S_EXECR) || (r_state == S_EXECI) || (r_state == S_ALUWB)) begin
      ALUControl = w_dec_alu;
      FlagW      = w_dec_flag;
      NoWrite    = w_dec_nw;
    end
    // Strobes stay quiet for the whole reset, not just from the next edge.
    if (reset) begin
      IRWrite = 1'b0; NextPC = 1'b0; MemW = 1'b0; RegW = 1'b0; PCS = 1'b0;
      FlagW = 2'b00; NoWrite = 1'b0; Illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a full-width build and an ALU_W=2 build
// driven by the same instruction stream.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [1:0] sh;
  logic       MemReady;

  logic       IRWrite, NextPC, AdrSrc, MemW, RegW, PCS, ALUSrcA, NoWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW;
  logic [3:0] ALUControl, st;

  logic       d2_IRWrite, d2_NextPC, d2_AdrSrc, d2_MemW, d2_RegW, d2_PCS, d2_ALUSrcA;
  logic       d2_NoWrite, d2_Illegal;
  logic [1:0] d2_ResultSrc, d2_ALUSrcB, d2_ImmSrc, d2_RegSrc, d2_FlagW, d2_ALUControl;
  logic [3:0] d2_st;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.ALU_W(4), .USE_MEMRDY(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .sh(sh),
    .MemReady(MemReady), .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
    .MemW(MemW), .RegW(RegW), .PCS(PCS), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .FlagW(FlagW), .NoWrite(NoWrite), .Illegal(Illegal), .o_dbg_state(st)
  );

  mc_control_fsm #(.ALU_W(2), .USE_MEMRDY(1'b1)) dut2 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .sh(sh),
    .MemReady(MemReady), .IRWrite(d2_IRWrite), .NextPC(d2_NextPC), .AdrSrc(d2_AdrSrc),
    .MemW(d2_MemW), .RegW(d2_RegW), .PCS(d2_PCS), .ResultSrc(d2_ResultSrc),
    .ALUSrcA(d2_ALUSrcA), .ALUSrcB(d2_ALUSrcB), .ImmSrc(d2_ImmSrc), .RegSrc(d2_RegSrc),
    .ALUControl(d2_ALUControl), .FlagW(d2_FlagW), .NoWrite(d2_NoWrite),
    .Illegal(d2_Illegal), .o_dbg_state(d2_st)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'b101001; Rd = 4'd1; sh = 2'b00; MemReady = 1'b1;
    tick(); tick();
    chk("rst_state", st, S_FETCH);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_nextpc", NextPC, 0);
    chk("rst_memw", MemW, 0);
    chk("rst_regw", RegW, 0);
    chk("rst_pcs", PCS, 0);
    chk("rst_flagw", FlagW, 0);
    chk("rst_nowrite", NoWrite, 0);
    chk("rst_illegal", Illegal, 0);

    // ADDS R1,R2,#5
    reset = 1'b0; #1;
    chk("fetch_irwrite", IRWrite, 1);
    chk("fetch_nextpc", NextPC, 1);
    chk("fetch_adrsrc", AdrSrc, 0);
    chk("fetch_alusrca", ALUSrcA, 1);
    chk("fetch_alusrcb", ALUSrcB, 2);
    chk("fetch_resultsrc", ResultSrc, 2);
    tick();
    chk("adds_dec_state", st, S_DECODE);
    chk("adds_dec_illegal", Illegal, 0);
    tick();
    chk("adds_exec_state", st, S_EXECI);
    chk("adds_exec_alusrcb", ALUSrcB, 1);
    chk("adds_exec_immsrc", ImmSrc, 0);
    chk("adds_exec_aluctl", ALUControl, 0);
    chk("adds_exec_flagw", FlagW, 3);
    tick();
    chk("adds_wb_state", st, S_ALUWB);
    chk("adds_wb_regw", RegW, 1);
    chk("adds_wb_pcs", PCS, 0);
    chk("adds_wb_resultsrc", ResultSrc, 0);
    chk("adds_wb_flagw", FlagW, 3);
    chk("adds_wb_aluctl", ALUControl, 0);
    tick();
    chk("adds_done_state", st, S_FETCH);

    // Fetch wait state
    MemReady = 1'b0; #1;
    chk("fetch_wait_irwrite", IRWrite, 0);
    chk("fetch_wait_nextpc", NextPC, 0);
    tick();
    chk("fetch_wait_state", st, S_FETCH);
    MemReady = 1'b1;

    // LDR R0,[R1,#4] with two wait cycles in MEMRD: 7 cycles total
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd0;
    tick();
    chk("ldr_c2_state", st, S_DECODE);
    tick();
    chk("ldr_c3_state", st, S_MEMADR);
    chk("ldr_c3_alusrcb", ALUSrcB, 1);
    chk("ldr_c3_immsrc", ImmSrc, 1);
    chk("ldr_c3_aluctl", ALUControl, 0);
    tick();
    MemReady = 1'b0; #1;
    chk("ldr_c4_state", st, S_MEMRD);
    chk("ldr_c4_adrsrc", AdrSrc, 1);
    chk("ldr_c4_regw", RegW, 0);
    tick();
    chk("ldr_c5_state", st, S_MEMRD);
    chk("ldr_c5_regw", RegW, 0);
    tick();
    chk("ldr_c6_state", st, S_MEMRD);
    MemReady = 1'b1;
    tick();
    chk("ldr_c7_state", st, S_MEMWB);
    chk("ldr_c7_regw", RegW, 1);
    chk("ldr_c7_resultsrc", ResultSrc, 1);
    chk("ldr_c7_pcs", PCS, 0);
    tick();
    chk("ldr_done_state", st, S_FETCH);
    chk("ldr_done_regw", RegW, 0);

    // CMP R3,R4
    Op = 2'b00; Funct = 6'b010101; Rd = 4'd0;
    tick(); tick();
    chk("cmp_exec_state", st, S_EXECR);
    chk("cmp_exec_alusrcb", ALUSrcB, 0);
    chk("cmp_exec_aluctl", ALUControl, 1);
    chk("cmp_exec_nowrite", NoWrite, 1);
    chk("cmp_exec_flagw", FlagW, 3);
    tick();
    chk("cmp_wb_state", st, S_ALUWB);
    chk("cmp_wb_regw", RegW, 0);
    chk("cmp_wb_pcs", PCS, 0);
    tick();

    // cmd 1010 with S=0 is unimplemented
    Funct = 6'b010100;
    tick();
    chk("cmp_nos_illegal", Illegal, 1);
    chk("cmp_nos_regw", RegW, 0);
    chk("cmp_nos_memw", MemW, 0);
    chk("cmp_nos_pcs", PCS, 0);
    tick();
    chk("cmp_nos_next_state", st, S_FETCH);
    chk("cmp_nos_pulse_end", Illegal, 0);

    // B
    Op = 2'b10; Funct = 6'b100000;
    tick(); tick();
    chk("b_state", st, S_BRANCH);
    chk("b_pcs", PCS, 1);
    chk("b_immsrc", ImmSrc, 2);
    chk("b_regsrc", RegSrc, 1);
    chk("b_alusrcb", ALUSrcB, 1);
    chk("b_resultsrc", ResultSrc, 2);
    chk("b_regw", RegW, 0);
    tick();
    chk("b_done_state", st, S_FETCH);

    // MOV PC,R2 (shift op, LSL)
    Op = 2'b00; Funct = 6'b011010; sh = 2'b00; Rd = 4'd15;
    tick(); tick();
    chk("mov_exec_state", st, S_EXECR);
    chk("mov_exec_aluctl", ALUControl, 8'h08);
    chk("mov_exec_flagw", FlagW, 0);
    sh = 2'b10; #1;
    chk("mov_asr_aluctl", ALUControl, 8'h0a);
    sh = 2'b00;
    tick();
    chk("mov_wb_regw", RegW, 1);
    chk("mov_wb_pcs", PCS, 1);
    tick();

    // EOR: legal at ALU_W=4, illegal at ALU_W=2
    reset = 1'b1; tick(); reset = 1'b0;
    Op = 2'b00; Funct = 6'b000010; Rd = 4'd1;
    tick();
    chk("eor_w2_illegal", d2_Illegal, 1);
    chk("eor_w2_regw", d2_RegW, 0);
    chk("eor_w2_memw", d2_MemW, 0);
    chk("eor_w2_pcs", d2_PCS, 0);
    chk("eor_w4_illegal", Illegal, 0);
    tick();
    chk("eor_w2_next_state", d2_st, S_FETCH);
    chk("eor_w4_state", st, S_EXECR);
    chk("eor_w4_aluctl", ALUControl, 4);
    tick();
    chk("eor_w4_regw", RegW, 1);
    chk("eor_w2_regw_later", d2_RegW, 0);

    // Op11 on the narrow build
    reset = 1'b1; tick(); reset = 1'b0;
    Op = 2'b11; Funct = 6'b000000;
    tick();
    chk("op11_w2_illegal", d2_Illegal, 1);
    chk("op11_w4_illegal", Illegal, 1);
    chk("op11_w2_regw", d2_RegW, 0);
    tick();
    chk("op11_w2_next_state", d2_st, S_FETCH);
    chk("op11_w4_next_state", st, S_FETCH);

    // STR aborted by reset while waiting in MEMWR
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd0;
    tick(); tick(); tick();
    chk("str_state", st, S_MEMWR);
    chk("str_memw", MemW, 1);
    chk("str_adrsrc", AdrSrc, 1);
    chk("str_regsrc", RegSrc, 2);
    MemReady = 1'b0;
    tick();
    chk("str_wait_state", st, S_MEMWR);
    chk("str_wait_memw", MemW, 1);
    reset = 1'b1; #1;
    chk("str_rst_memw", MemW, 0);
    tick();
    chk("str_rst_state", st, S_FETCH);
    chk("str_rst_memw2", MemW, 0);
    chk("str_rst_irwrite", IRWrite, 0);
    reset = 1'b0; MemReady = 1'b1; #1;
    chk("str_post_state", st, S_FETCH);
    chk("str_post_memw", MemW, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
